fwrisc_mdalu: RTL
=================

FWRISC_MDALU -- requirements
Module: fwrisc_mdalu

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand and result width; legal values are 8, 16, 32 and 64.
REQ-002 Parameter ENABLE_MULDIV, default 1, SHALL enable the MUL/DIVU/REMU ops; when 0, those ops SHALL complete as OP_XOR.
REQ-003 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 in_valid  input  1  SHALL indicate that op, op_a and op_b are valid.
REQ-006 in_ready  output  1  SHALL be high exactly when the unit is IDLE.
REQ-007 op  input  4  SHALL select the operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 CLR, 6 EQ, 7 LT, 8 LTU, 9 SLL, 10 SRL, 11 SRA, 12 MUL, 13 DIVU, 14 REMU; 15 SHALL act as XOR.
REQ-008 op_a, op_b  input  WIDTH  SHALL be the operands.
REQ-009 out_valid  output  1  SHALL indicate that out holds a result.
REQ-010 out_ready  input  1  SHALL indicate that the consumer takes the result.
REQ-011 out  output  WIDTH  SHALL be the registered result.

Function
REQ-012 The FSM SHALL have states IDLE, BUSY and DONE; a transfer is accepted on a rising edge in IDLE with in_valid=1, and operands SHALL be captured at that edge.
REQ-013 Single-cycle ops (0-8, shift with shamt=0, 15, and muldiv when disabled) SHALL go IDLE->DONE; out_valid SHALL rise 1 cycle after the accept edge.
REQ-014 Arithmetic SHALL be modulo 2^WIDTH; CLR = a & ~b; EQ/LT/LTU SHALL return 1 or 0 zero-extended; LT SHALL be signed, LTU unsigned.
REQ-015 Shift amount shamt SHALL be op_b[log2(WIDTH)-1:0]; upper op_b bits SHALL be ignored.
REQ-016 Shifts SHALL move one bit per BUSY cycle; out_valid SHALL rise 1+shamt cycles after the accept edge; SRA SHALL replicate the sign bit.
REQ-017 MUL SHALL return the low WIDTH bits of a*b using shift-add; DIVU/REMU SHALL use restoring division; all three SHALL raise out_valid exactly 1+WIDTH cycles after the accept edge.
REQ-018 Divide by zero SHALL return quotient all-ones and remainder op_a, with unchanged latency.
REQ-019 In DONE, out and out_valid SHALL hold stable until a rising edge with out_ready=1, which SHALL return to IDLE and deassert out_valid.
REQ-020 in_valid SHALL be ignored outside IDLE; no input SHALL be accepted in the cycle DONE completes (one bubble minimum).
REQ-021 Input changes during BUSY or DONE SHALL NOT affect the result in progress.
REQ-022 out_ready SHALL be ignored while out_valid=0.

Reset
REQ-023 Reset SHALL force IDLE, out_valid=0, out=0 and step counter=0 at the next edge, including mid-BUSY or DONE; an in-flight result SHALL be discarded.
REQ-024 in_ready SHALL be 0 while reset is high and 1 in the first cycle after reset deasserts.

Verification (WIDTH=32, ENABLE_MULDIV=1)
REQ-025 ADD a=0xFFFFFFFF, b=1 -> out=0 and out_valid 1 cycle after accept; LT a=0xFFFFFFFF, b=0 -> 1; LTU with the same operands -> 0.
REQ-026 SRA a=0x80000000, b=0x0000003F (shamt 31) -> out=0xFFFFFFFF after 32 cycles; SLL with b=0x20 (shamt 0) -> out=a after 1 cycle.
REQ-027 MUL a=0x00010001, b=0x00010001 -> out=0x00020001 after 33 cycles; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-028 DIVU a=0x1234, b=0 -> out=0xFFFFFFFF; REMU a=0x1234, b=0 -> out=0x1234; both after 33 cycles.
REQ-029 Hold out_ready=0 for 5 cycles in DONE -> out stable and in_ready=0 throughout; in_valid pulses during that time are ignored.
REQ-030 Assert reset 10 cycles into a MUL -> out_valid=0 and in_ready=1 after reset releases; a following ADD 2+3 -> 5.

Source files
------------

// File: rtl/fwrisc_mdalu_if.sv
// fwrisc_mdalu_if
//
// Purpose:
//    Bundles the operand/result handshake of the fwrisc_mdalu unit so the
//    producer and consumer sides can be connected as one bus.
//
// Signals:
//    in_valid  - request carries a valid op/op_a/op_b
//    in_ready  - unit is idle and will accept a request
//    op        - operation select (4 bits)
//    op_a/op_b - operands, WIDTH bits
//    out_valid - out holds a result
//    out_ready - consumer takes the result
//    out       - registered result, WIDTH bits
//
// Modports:
//    master - the side issuing requests and consuming results
//    slave  - the arithmetic unit itself
interface fwrisc_mdalu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;

    modport master (
        output in_valid, op, op_a, op_b, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, op, op_a, op_b, out_ready,
        output in_ready, out_valid, out
    );
endinterface

// File: rtl/fwrisc_mdalu.sv
// fwrisc_mdalu
//
// Purpose:
//    Small multi-cycle ALU. Logic/compare/add ops finish in one cycle,
//    shifts move one bit per cycle, and MUL/DIVU/REMU run a WIDTH-step
//    shift-add multiplier or restoring divider.
//
// Ports:
//    clock - single clock, rising edge
//    reset - synchronous, active-high
//    bus   - fwrisc_mdalu_if slave modport (request/result handshake)
//
// Parameters:
//    WIDTH         - operand/result width (8, 16, 32 or 64)
//    ENABLE_MULDIV - when 0, MUL/DIVU/REMU complete as XOR
module fwrisc_mdalu #(
    parameter int WIDTH         = 32,
    parameter bit ENABLE_MULDIV = 1'b1
) (
    input logic            clock,
    input logic            reset,
    fwrisc_mdalu_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_CLR  = 4'd5;
    localparam logic [3:0] OP_EQ   = 4'd6;
    localparam logic [3:0] OP_LT   = 4'd7;
    localparam logic [3:0] OP_LTU  = 4'd8;
    localparam logic [3:0] OP_SLL  = 4'd9;
    localparam logic [3:0] OP_SRL  = 4'd10;
    localparam logic [3:0] OP_SRA  = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12;
    localparam logic [3:0] OP_DIVU = 4'd13;
    localparam logic [3:0] OP_REMU = 4'd14;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] out_q, out_d;

    logic [SHW-1:0]   shamt;
    logic             is_shift;
    logic             is_muldiv;
    logic [WIDTH-1:0] single_res;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] step_a;
    logic [WIDTH-1:0] step_acc;

    // in_ready is gated by reset so no request looks acceptable while the
    // unit is being cleared.
    assign bus.in_ready  = (state_q == IDLE) && !reset;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out       = out_q;

    // Request decode, single-cycle results and one step of the iterative
    // datapath, plus the IDLE/BUSY/DONE next-state logic.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        out_d     = out_q;

        shamt     = bus.op_b[SHW-1:0];
        is_shift  = (bus.op == OP_SLL) || (bus.op == OP_SRL) || (bus.op == OP_SRA);
        is_muldiv = ENABLE_MULDIV &&
                    ((bus.op == OP_MUL) || (bus.op == OP_DIVU) || (bus.op == OP_REMU));

        case (bus.op)
            OP_ADD:  single_res = bus.op_a + bus.op_b;
            OP_SUB:  single_res = bus.op_a - bus.op_b;
            OP_AND:  single_res = bus.op_a & bus.op_b;
            OP_OR:   single_res = bus.op_a | bus.op_b;
            OP_CLR:  single_res = bus.op_a & ~bus.op_b;
            OP_EQ:   single_res = {{(WIDTH-1){1'b0}}, (bus.op_a == bus.op_b)};
            OP_LT:   single_res = {{(WIDTH-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
            OP_LTU:  single_res = {{(WIDTH-1){1'b0}}, (bus.op_a < bus.op_b)};
            OP_SLL, OP_SRL, OP_SRA: single_res = bus.op_a;
            default: single_res = bus.op_a ^ bus.op_b;
        endcase

        // Restoring-division step: bring in the next dividend bit and
        // subtract the divisor; a set borrow bit means "restore".
        rem_shift = {acc_q, a_q[WIDTH-1]};
        diff      = rem_shift - {1'b0, b_q};

        step_a    = a_q;
        step_acc  = acc_q;
        case (op_q)
            OP_SLL: step_a = a_q << 1;
            OP_SRL: step_a = a_q >> 1;
            OP_SRA: step_a = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
            OP_MUL: begin
                step_a   = a_q << 1;
                step_acc = b_q[0] ? (acc_q + a_q) : acc_q;
            end
            default: begin
                step_a   = {a_q[WIDTH-2:0], ~diff[WIDTH]};
                step_acc = diff[WIDTH] ? rem_shift[WIDTH-1:0] : diff[WIDTH-1:0];
            end
        endcase

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    op_d  = bus.op;
                    a_d   = bus.op_a;
                    b_d   = bus.op_b;
                    acc_d = '0;
                    if (is_muldiv) begin
                        cnt_d   = CW'(WIDTH);
                        state_d = BUSY;
                    end else if (is_shift && (shamt != '0)) begin
                        cnt_d   = CW'(shamt);
                        state_d = BUSY;
                    end else begin
                        out_d   = single_res;
                        state_d = DONE;
                    end
                end
            end
            BUSY: begin
                a_d   = step_a;
                acc_d = step_acc;
                b_d   = (op_q == OP_MUL) ? (b_q >> 1) : b_q;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    // Product and remainder live in acc, quotient and
                    // shifted value in a.
                    out_d   = ((op_q == OP_MUL) || (op_q == OP_REMU)) ? step_acc : step_a;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset discards any in-flight result.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end
endmodule
